// File: rtl/nn_inference_sequencer.sv
// nn_inference_sequencer
// Launches one forward pass of the slow-clocked neural_network per start
// request. The start level is synchronised and edge-detected, nn_start is
// stretched over several slow-clock periods, done is awaited with a timeout,
// and the argmax is latched into a stable result register for the display.
// Optional build macro: AUTO_RERUN_EN (rerun while start is held high).
//
// state     | meaning
// IDLE      | waiting for a start edge with drawing inactive
// LAUNCH    | nn_start high for START_HOLD cycles
// WAIT_DONE | waiting for synchronised done, timeout counter running
// CAPTURE   | latching argmax (out-of-range maps to 10) into result
// DRAIN     | waiting for done to drop so it cannot complete the next run
// ERROR     | last run timed out; a new start edge relaunches

module nn_inference_sequencer #(
  parameter int unsigned START_HOLD     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned RERUN_GAP      = 1024
) (
  input  logic       clk_i,
  input  logic       resetn_i,
  input  logic       start_req_i,
  input  logic       draw_active_i,
  input  logic       nn_done_i,
  input  logic [3:0] nn_argmax_i,
  output logic       nn_start_o,
  output logic [3:0] result_o,
  output logic       result_valid_o,
  output logic       busy_o,
  output logic       timeout_err_o,
  output logic [2:0] state_dbg_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_WAIT_DONE = 3'd2;
  localparam logic [2:0] S_CAPTURE   = 3'd3;
  localparam logic [2:0] S_DRAIN     = 3'd4;
  localparam logic [2:0] S_ERROR     = 3'd5;

  localparam int unsigned HOLD_W = $clog2(START_HOLD + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_CYCLES);

  // Counters below cannot represent degenerate parameter values
  if (START_HOLD < 1 || TIMEOUT_CYCLES < 2 || RERUN_GAP < 1) begin : g_param_check
    $error("nn_inference_sequencer: invalid parameter values");
  end

  logic              start_s1_q, start_s2_q, start_prev_q;
  logic              done_s1_q, done_s2_q;
  logic              start_edge, launch_ok;
  logic [2:0]        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [3:0]        result_q, result_d;
  logic              valid_q, valid_d;
  logic              terr_q, terr_d;
  logic              nn_start_q, busy_q;

`ifdef AUTO_RERUN_EN
  localparam int unsigned GAP_W = $clog2(RERUN_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RERUN_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(RERUN_GAP);

  logic [GAP_W-1:0] gap_q, gap_d;
  logic             ran_ok_q, ran_ok_d;
  logic             rerun_q, rerun_d;
  logic             gap_cond, auto_go;
`endif

  // Two-flop synchronisers for the async start switch and slow-domain done
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      start_s1_q   <= 1'b0;
      start_s2_q   <= 1'b0;
      start_prev_q <= 1'b0;
      done_s1_q    <= 1'b0;
      done_s2_q    <= 1'b0;
    end else begin
      start_s1_q   <= start_req_i;
      start_s2_q   <= start_s1_q;
      start_prev_q <= start_s2_q;
      done_s1_q    <= nn_done_i;
      done_s2_q    <= done_s1_q;
    end
  end

  assign start_edge = start_s2_q & ~start_prev_q;
  assign launch_ok  = start_edge & ~draw_active_i;

`ifdef AUTO_RERUN_EN
  // Gap counter only runs while a completed result sits in IDLE with start held
  assign gap_cond = (state_q == S_IDLE) && ran_ok_q && start_s2_q && !draw_active_i;
  assign auto_go  = gap_cond && (gap_q == GAP_LAST);
  assign gap_d    = !gap_cond ? '0 :
                    (gap_q == GAP_MAX) ? gap_q : gap_q + GAP_W'(1);

  // Rerun bookkeeping: gap count, completed-run flag, auto-launch marker
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      gap_q    <= '0;
      ran_ok_q <= 1'b0;
      rerun_q  <= 1'b0;
    end else begin
      gap_q    <= gap_d;
      ran_ok_q <= ran_ok_d;
      rerun_q  <= rerun_d;
    end
  end
`endif

  // Next-state, counter and result logic
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    to_d     = to_q;
    result_d = result_q;
    valid_d  = valid_q;
    terr_d   = terr_q;
`ifdef AUTO_RERUN_EN
    ran_ok_d = ran_ok_q;
    rerun_d  = rerun_q;
`endif
    case (state_q)
      S_IDLE: begin
        hold_d = '0;
        to_d   = '0;
        if (launch_ok) begin
          state_d = S_LAUNCH;
`ifdef AUTO_RERUN_EN
          rerun_d = 1'b0;
        end else if (auto_go) begin
          state_d = S_LAUNCH;
          rerun_d = 1'b1;
`endif
        end
      end
      S_LAUNCH: begin
        // An automatic rerun keeps showing the previous result until capture
`ifdef AUTO_RERUN_EN
        if (!rerun_q) valid_d = 1'b0;
`else
        valid_d = 1'b0;
`endif
        terr_d = 1'b0;
        to_d   = '0;
        if (hold_q == HOLD_LAST) begin
          state_d = S_WAIT_DONE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_WAIT_DONE: begin
        to_d = (to_q == TO_MAX) ? to_q : to_q + TO_W'(1);
        if (done_s2_q) begin
          state_d = S_CAPTURE;
        end else if (to_d == TO_MAX) begin
          state_d = S_ERROR;
        end
      end
      S_CAPTURE: begin
        result_d = (nn_argmax_i > 4'd9) ? 4'd10 : nn_argmax_i;
        valid_d  = 1'b1;
        state_d  = S_DRAIN;
`ifdef AUTO_RERUN_EN
        ran_ok_d = 1'b1;
`endif
      end
      S_DRAIN: begin
        if (!done_s2_q) state_d = S_IDLE;
      end
      S_ERROR: begin
        result_d = 4'd10;
        terr_d   = 1'b1;
        valid_d  = 1'b0;
        hold_d   = '0;
`ifdef AUTO_RERUN_EN
        ran_ok_d = 1'b0;
`endif
        if (launch_ok) begin
          state_d = S_LAUNCH;
`ifdef AUTO_RERUN_EN
          rerun_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; nn_start and busy follow the next state
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      to_q       <= '0;
      result_q   <= 4'd15;
      valid_q    <= 1'b0;
      terr_q     <= 1'b0;
      nn_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      to_q       <= to_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      terr_q     <= terr_d;
      nn_start_q <= (state_d == S_LAUNCH);
      busy_q     <= (state_d == S_LAUNCH) || (state_d == S_WAIT_DONE) ||
                    (state_d == S_CAPTURE) || (state_d == S_DRAIN);
    end
  end

  assign nn_start_o     = nn_start_q;
  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign busy_o         = busy_q;
  assign timeout_err_o  = terr_q;
  assign state_dbg_o    = state_q;

endmodule
